// File: rtl/uart_rx_fifo.sv
// Captures completed UART characters with their parity flag into a show-ahead FIFO and acks the receiver.
// Push lands one cycle after rx_done_i is seen; a character arriving while full is dropped and sets overrun.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     parity_error_i,
    output logic                     host_read_data_o,
    input  logic                     pop_i,
    input  logic                     clr_overrun_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_parity_err_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic              par_err;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ACK,
        CAP_WAIT
    } cap_state_t;

    cap_state_t    state;
    cap_state_t    state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          par_pend;
    logic          push;
    logic          drop;
    logic          pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The full check happens before any same-cycle pop, so a character arriving while full is always dropped.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (rx_done_i) begin
                    if (full_o) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    state_nxt = CAP_ACK;
                end
            end
            CAP_ACK:  state_nxt = CAP_WAIT;
            CAP_WAIT: begin
                if (!rx_done_i) begin
                    state_nxt = CAP_IDLE;
                end
            end
            default:  state_nxt = CAP_IDLE;
        endcase
    end

    assign host_read_data_o = (state == CAP_ACK);
    assign pop              = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= '{par_err: par_pend | parity_error_i, data: rx_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            par_pend  <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
            // The receiver's parity error may vanish before done rises, so hold it until the character is consumed.
            if (parity_error_i) begin
                par_pend <= 1'b1;
            end else if (push || drop) begin
                par_pend <= 1'b0;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign empty_o         = (count_o == '0);
    assign full_o          = (count_o == FULL_CNT);
    assign head            = mem[rd_ptr];
    assign rd_data_o       = empty_o ? '0 : head.data;
    assign rd_parity_err_o = empty_o ? 1'b0 : head.par_err;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed character from the receiver's level-held done/data/parity outputs and returns the one-cycle read-acknowledge that clears the receiver. Each character is stored with its parity-error flag in a show-ahead FIFO, which the APB register block drains. The block reports occupancy, full/empty and a sticky overrun flag so software can poll or raise interrupts.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 8: character width; the receiver right-justifies 5–8 bit characters into this field.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_done_i`  in  1  receiver "character ready"; level, held until acknowledged.
- `rx_data_i`  in  DATA_W  received character; valid while `rx_done_i`=1.
- `parity_error_i`  in  1  receiver parity-error indication; may pulse before `rx_done_i` rises.
- `host_read_data_o`  out  1  one-cycle acknowledge to the receiver; clears its done flag.
- `pop_i`  in  1  register block consumes the head entry (APB read of the RX data register).
- `clr_overrun_i`  in  1  clears `overrun_o` (W1C from the register block).
- `rd_data_o`  out  DATA_W  head character; 0 when empty.
- `rd_parity_err_o`  out  1  parity flag of the head entry; 0 when empty.
- `empty_o`  out  1  FIFO empty.
- `full_o`  out  1  FIFO full.
- `count_o`  out  $clog2(DEPTH)+1  number of stored entries.
- `overrun_o`  out  1  sticky; a character was dropped because the FIFO was full.

## Operation
- Storage holds DEPTH entries of {parity_err, data}, DATA_W+1 bits each.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `count_o` is a separate counter: +1 on push only, −1 on pop only, unchanged when both happen or neither happens.
- Parity pending latch `par_pend`:
  - Set on any cycle with `parity_error_i`=1.
  - Its value is ORed into the entry on push.
  - Cleared on push, unless `parity_error_i`=1 in that same cycle.
  - Required because the receiver's parity error can be gone by the time `rx_done_i` rises.
- Capture FSM has three states:
  - CAP_IDLE: if `rx_done_i`=1, push the character, or drop it if full, then go to CAP_ACK.
    - Push: write {par_pend|parity_error_i, rx_data_i} at the write pointer.
    - Drop (full): no write, set `overrun_o`, clear `par_pend`.
  - CAP_ACK: `host_read_data_o`=1 (Moore output); always go to CAP_WAIT.
  - CAP_WAIT: stay until `rx_done_i`=0, then go to CAP_IDLE. This guarantees one push per character.
- Read side is show-ahead: `rd_data_o` and `rd_parity_err_o` reflect the head entry while not empty.
  - `pop_i` with `empty_o`=1 is ignored: pointers and count are unchanged and no error is raised.
- Overrun:
  - `clr_overrun_i` clears `overrun_o`.
  - If a drop and `clr_overrun_i` occur in the same cycle, set wins.
- Push while full is never performed. Pop and push in the same cycle while full is impossible, because the full check precedes the write decision; the character is dropped.

## Timing
- Reset (synchronous, takes effect at the clock edge while `rst`=1):
  - FSM returns to CAP_IDLE.
  - Pointers, count and `par_pend` go to 0.
  - Outputs: `empty_o`=1, `full_o`=0, `count_o`=0, `overrun_o`=0, `host_read_data_o`=0, `rd_data_o`=0, `rd_parity_err_o`=0.
  - Storage contents are not reset.
- Reset mid-capture:
  - Any in-flight acknowledge is abandoned.
  - If `rx_done_i` is still 1 after reset releases, the character is captured as new in the first CAP_IDLE cycle.
- Push latency: `rx_done_i` seen high in CAP_IDLE in cycle N → entry written at the end of cycle N.
  - In cycle N+1: `empty_o`/`full_o`/`count_o` are updated and `host_read_data_o`=1.
  - In cycle N+2: the receiver drops `rx_done_i` (registered), giving CAP_WAIT → CAP_IDLE.
  - Minimum spacing between captures is 3 cycles. This is negligible against a 16× oversampled bit time.
- Pop latency: `pop_i` in cycle M → the new head appears on `rd_data_o` in cycle M+1, and count/flags update in M+1.
- Flags are registered, or derived from the registered count: `empty_o` = (count==0), `full_o` = (count==DEPTH).

## Test plan
- Single character: after reset, assert `rx_data_i`=8'hA5 and `rx_done_i`=1 until acknowledged.
  - → exactly one `host_read_data_o` pulse, in cycle N+1.
  - → `empty_o`=0, `count_o`=1, `rd_data_o`=8'hA5, `rd_parity_err_o`=0.
  - `pop_i` → `empty_o`=1, `rd_data_o`=0.
- Parity capture: pulse `parity_error_i` for 1 cycle, 5 cycles before `rx_done_i` rises with 8'h3C.
  - → head entry is {1, 8'h3C}.
  - The next character, sent without a parity pulse, stores parity 0.
- Fill and overrun (DEPTH=16): push 16 characters 8'h00..8'h0F → `full_o`=1, `count_o`=16.
  - A 17th character 8'hFF is still acknowledged, is not stored, and sets `overrun_o`=1.
  - 16 pops return 8'h00..8'h0F in order.
- Wrap and simultaneous push/pop:
  - Keep 8 entries resident and cycle 40 characters so the pointers wrap.
  - On a cycle where push and pop coincide, `count_o` is unchanged.
  - Data order is preserved.
- Edge controls:
  - `pop_i` while empty → no state change.
  - `clr_overrun_i` coincident with a drop → `overrun_o` stays 1; clearing it alone → 0.
  - Assert `rst` during CAP_ACK with `rx_done_i` held → after release, exactly one capture of that character and `count_o`=1.
